// File: rtl/enigma_core.sv
// enigma_core: three-rotor Enigma cipher engine (UKW-B reflector, rings at A,
// no plugboard). Encrypts one letter per request through a fixed sequence of
// one-cycle stages and reports the ciphertext with the current rotor window.
//
// Ports:
//   clk_in            system clock
//   rst_in            synchronous active-high reset
//   rotor_valid_in    pulse: load rotor_select_in / rotor_initial_in (IDLE only)
//   rotor_select_in   [8:6] left, [5:3] middle, [2:0] right rotor code (0=I..7=VIII)
//   rotor_initial_in  [14:10] left, [9:5] middle, [4:0] right start position
//   letter_valid_in   pulse: encrypt char_in (IDLE only, char_in <= 25)
//   char_in           plaintext letter 0=A..25=Z
//   ready_out         high only while idle
//   char_out          ciphertext letter, held until the next result
//   char_valid_out    one-cycle pulse marking a new char_out
//   rotor_pos_out     current rotor positions, packed like rotor_initial_in
module enigma_core #(
   parameter int NUM_ROTORS = 8
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    rotor_valid_in,
   input  logic [3*$clog2(NUM_ROTORS)-1:0] rotor_select_in,
   input  logic [14:0]             rotor_initial_in,
   input  logic                    letter_valid_in,
   input  logic [4:0]              char_in,
   output logic                    ready_out,
   output logic [4:0]              char_out,
   output logic                    char_valid_out,
   output logic [14:0]             rotor_pos_out
);

   localparam int SEL_W = $clog2(NUM_ROTORS);

   // Wiring tables as ASCII strings: first character is the output for input A.
   localparam logic [207:0] ROT_I    = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
   localparam logic [207:0] ROT_II   = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
   localparam logic [207:0] ROT_III  = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
   localparam logic [207:0] ROT_IV   = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
   localparam logic [207:0] ROT_V    = "VZBRGITYUPSDNHLXAWMJQOFECK";
   localparam logic [207:0] ROT_VI   = "JPGVOUMFYQBENHZRDKASXLICTW";
   localparam logic [207:0] ROT_VII  = "NZJHGRCXMYSWBOUFAIVLPEKQDT";
   localparam logic [207:0] ROT_VIII = "FKQHTLXOCBJSPDZRAMEWNIUYGV";
   localparam logic [207:0] UKW_B    = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

   typedef enum logic [3:0] {
      S_IDLE, S_STEP, S_F_R, S_F_M, S_F_L, S_REFL, S_B_L, S_B_M, S_B_R, S_DONE
   } state_t;

   // Low five bits of an upper-case ASCII letter are 1..26, so subtract one.
   function automatic logic [4:0] rom_char(input logic [207:0] tbl, input logic [4:0] idx);
      return tbl[(8'd200 - {idx, 3'b000}) +: 5] - 5'd1;
   endfunction

   function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
      logic [5:0] s;
      s = {1'b0, a} + {1'b0, b};
      s = (s >= 6'd26) ? (s - 6'd26) : s;
      return s[4:0];
   endfunction

   // Negative differences wrap modulo 64; adding 26 lands back in 0..25.
   function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
      logic [5:0] s;
      s = {1'b0, a} - {1'b0, b};
      s = (a < b) ? (s + 6'd26) : s;
      return s[4:0];
   endfunction

   function automatic logic [4:0] wire_fwd(input logic [SEL_W-1:0] sel, input logic [4:0] idx);
      logic [4:0] res;
      case (sel)
         3'd0:    res = rom_char(ROT_I, idx);
         3'd1:    res = rom_char(ROT_II, idx);
         3'd2:    res = rom_char(ROT_III, idx);
         3'd3:    res = rom_char(ROT_IV, idx);
         3'd4:    res = rom_char(ROT_V, idx);
         3'd5:    res = rom_char(ROT_VI, idx);
         3'd6:    res = rom_char(ROT_VII, idx);
         default: res = rom_char(ROT_VIII, idx);
      endcase
      return res;
   endfunction

   // Inverse wiring: the forward ROM is a permutation, so exactly one entry matches.
   function automatic logic [4:0] wire_inv(input logic [SEL_W-1:0] sel, input logic [4:0] c);
      logic [4:0] res;
      res = 5'd0;
      for (int k = 0; k < 26; k++) begin
         res = (wire_fwd(sel, 5'(k)) == c) ? 5'(k) : res;
      end
      return res;
   endfunction

   function automatic logic is_notch(input logic [SEL_W-1:0] sel, input logic [4:0] pos);
      logic hit;
      case (sel)
         3'd0:    hit = (pos == 5'd16);
         3'd1:    hit = (pos == 5'd4);
         3'd2:    hit = (pos == 5'd21);
         3'd3:    hit = (pos == 5'd9);
         3'd4:    hit = (pos == 5'd25);
         default: hit = (pos == 5'd12) || (pos == 5'd25);
      endcase
      return hit;
   endfunction

   function automatic logic [4:0] clamp_pos(input logic [4:0] p);
      return (p >= 5'd26) ? 5'd0 : p;
   endfunction

   function automatic logic [4:0] inc26(input logic [4:0] p);
      return (p == 5'd25) ? 5'd0 : (p + 5'd1);
   endfunction

   state_t           state_r;
   logic [SEL_W-1:0] sel_l_r, sel_m_r, sel_rt_r;
   logic [4:0]       pos_l_r, pos_m_r, pos_rt_r;
   logic [4:0]       cur_r;
   logic [4:0]       char_out_r;
   logic             char_valid_r;
   logic             ready_r;

   logic [SEL_W-1:0] stage_sel_s;
   logic [4:0]       stage_pos_s;
   logic             stage_inv_s;
   logic [4:0]       stage_out_s;
   logic             step_mid_s;
   logic             step_left_s;

   // Pick the rotor, position and direction used by the current pass stage.
   always_comb begin
      stage_sel_s = sel_rt_r;
      stage_pos_s = pos_rt_r;
      stage_inv_s = 1'b0;
      case (state_r)
         S_F_M:   begin stage_sel_s = sel_m_r;  stage_pos_s = pos_m_r;  end
         S_F_L:   begin stage_sel_s = sel_l_r;  stage_pos_s = pos_l_r;  end
         S_B_L:   begin stage_sel_s = sel_l_r;  stage_pos_s = pos_l_r;  stage_inv_s = 1'b1; end
         S_B_M:   begin stage_sel_s = sel_m_r;  stage_pos_s = pos_m_r;  stage_inv_s = 1'b1; end
         S_B_R:   begin stage_sel_s = sel_rt_r; stage_pos_s = pos_rt_r; stage_inv_s = 1'b1; end
         default: begin stage_sel_s = sel_rt_r; stage_pos_s = pos_rt_r; stage_inv_s = 1'b0; end
      endcase
   end

   // One substitution step: reflector in REFL, otherwise a rotor pass.
   always_comb begin
      if (state_r == S_REFL) begin
         stage_out_s = rom_char(UKW_B, cur_r);
      end else if (stage_inv_s) begin
         stage_out_s = sub26(wire_inv(stage_sel_s, add26(cur_r, stage_pos_s)), stage_pos_s);
      end else begin
         stage_out_s = sub26(wire_fwd(stage_sel_s, add26(cur_r, stage_pos_s)), stage_pos_s);
      end
   end

   // Stepping decisions from pre-step positions; middle notch causes the double-step.
   always_comb begin
      step_mid_s  = is_notch(sel_rt_r, pos_rt_r) || is_notch(sel_m_r, pos_m_r);
      step_left_s = is_notch(sel_m_r, pos_m_r);
   end

   // Control FSM, rotor configuration and registered outputs.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_r      <= S_IDLE;
         sel_l_r      <= 3'd0;
         sel_m_r      <= 3'd1;
         sel_rt_r     <= 3'd2;
         pos_l_r      <= 5'd0;
         pos_m_r      <= 5'd0;
         pos_rt_r     <= 5'd0;
         cur_r        <= 5'd0;
         char_out_r   <= 5'd0;
         char_valid_r <= 1'b0;
         ready_r      <= 1'b1;
      end else begin
         char_valid_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               // Config load wins over a simultaneous letter request.
               if (rotor_valid_in) begin
                  sel_l_r  <= rotor_select_in[8:6];
                  sel_m_r  <= rotor_select_in[5:3];
                  sel_rt_r <= rotor_select_in[2:0];
                  pos_l_r  <= clamp_pos(rotor_initial_in[14:10]);
                  pos_m_r  <= clamp_pos(rotor_initial_in[9:5]);
                  pos_rt_r <= clamp_pos(rotor_initial_in[4:0]);
               end else if (letter_valid_in && (char_in <= 5'd25)) begin
                  cur_r   <= char_in;
                  state_r <= S_STEP;
                  ready_r <= 1'b0;
               end else begin
                  ready_r <= 1'b1;
               end
            end
            S_STEP: begin
               pos_rt_r <= inc26(pos_rt_r);
               pos_m_r  <= step_mid_s  ? inc26(pos_m_r) : pos_m_r;
               pos_l_r  <= step_left_s ? inc26(pos_l_r) : pos_l_r;
               state_r  <= S_F_R;
            end
            S_F_R:  begin cur_r <= stage_out_s; state_r <= S_F_M;  end
            S_F_M:  begin cur_r <= stage_out_s; state_r <= S_F_L;  end
            S_F_L:  begin cur_r <= stage_out_s; state_r <= S_REFL; end
            S_REFL: begin cur_r <= stage_out_s; state_r <= S_B_L;  end
            S_B_L:  begin cur_r <= stage_out_s; state_r <= S_B_M;  end
            S_B_M:  begin cur_r <= stage_out_s; state_r <= S_B_R;  end
            S_B_R: begin
               char_out_r   <= stage_out_s;
               char_valid_r <= 1'b1;
               state_r      <= S_DONE;
            end
            S_DONE: begin
               state_r <= S_IDLE;
               ready_r <= 1'b1;
            end
            default: begin
               state_r <= S_IDLE;
               ready_r <= 1'b1;
            end
         endcase
      end
   end

   assign ready_out      = ready_r;
   assign char_out       = char_out_r;
   assign char_valid_out = char_valid_r;
   assign rotor_pos_out  = {pos_l_r, pos_m_r, pos_rt_r};

endmodule

// File: tb/tb_enigma_core.sv
// Testbench for enigma_core: fixed vector table from known Enigma traffic,
// hand sequences for busy/illegal/reset corner cases, and random traffic
// checked against an arithmetic Enigma model built from the wiring strings.
module tb_enigma_core;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rotor_valid_in;
   logic [8:0]  rotor_select_in;
   logic [14:0] rotor_initial_in;
   logic        letter_valid_in;
   logic [4:0]  char_in;
   logic        ready_out;
   logic [4:0]  char_out;
   logic        char_valid_out;
   logic [14:0] rotor_pos_out;

   enigma_core #(.NUM_ROTORS(8)) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .rotor_valid_in   (rotor_valid_in),
      .rotor_select_in  (rotor_select_in),
      .rotor_initial_in (rotor_initial_in),
      .letter_valid_in  (letter_valid_in),
      .char_in          (char_in),
      .ready_out        (ready_out),
      .char_out         (char_out),
      .char_valid_out   (char_valid_out),
      .rotor_pos_out    (rotor_pos_out)
   );

   always #5 clk_in = ~clk_in;

   // DONE is the ninth cycle after the accept edge, i.e. it begins on edge 8.
   localparam int LAT_EDGES = 8;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- reference model ----------------
   string W_STR [8] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                        "BDFHJLCPRTXVZNYEIWGAKMUSQO", "ESOVPZJAYQUIRHXLNFTGKDCMWB",
                        "VZBRGITYUPSDNHLXAWMJQOFECK", "JPGVOUMFYQBENHZRDKASXLICTW",
                        "NZJHGRCXMYSWBOUFAIVLPEKQDT", "FKQHTLXOCBJSPDZRAMEWNIUYGV"};
   string R_STR = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
   int NOTCH1 [5] = '{16, 4, 21, 9, 25};
   int wt [8][26];
   int wi [8][26];
   int rf [26];
   int m_sel [3];   // 0 left, 1 middle, 2 right
   int m_pos [3];

   task automatic build_tables();
      for (int r = 0; r < 8; r++)
         for (int k = 0; k < 26; k++) begin
            wt[r][k] = int'(W_STR[r].getc(k)) - 65;
            wi[r][wt[r][k]] = k;
         end
      for (int k = 0; k < 26; k++) rf[k] = int'(R_STR.getc(k)) - 65;
   endtask

   function automatic bit m_notch(int r, int p);
      if (r < 5) return p == NOTCH1[r];
      return (p == 12) || (p == 25);
   endfunction

   function automatic int model_pos();
      return m_pos[0] * 1024 + m_pos[1] * 32 + m_pos[2];
   endfunction

   task automatic model_reset();
      m_sel[0] = 0; m_sel[1] = 1; m_sel[2] = 2;
      m_pos[0] = 0; m_pos[1] = 0; m_pos[2] = 0;
   endtask

   task automatic model_load(input logic [8:0] sel, input logic [14:0] init);
      int f [3];
      m_sel[0] = int'(sel[8:6]); m_sel[1] = int'(sel[5:3]); m_sel[2] = int'(sel[2:0]);
      f[0] = int'(init[14:10]); f[1] = int'(init[9:5]); f[2] = int'(init[4:0]);
      for (int i = 0; i < 3; i++) m_pos[i] = (f[i] >= 26) ? 0 : f[i];
   endtask

   task automatic model_press(input int c, output int res);
      bit mid, left;
      int x;
      mid  = m_notch(m_sel[2], m_pos[2]) || m_notch(m_sel[1], m_pos[1]);
      left = m_notch(m_sel[1], m_pos[1]);
      m_pos[2] = (m_pos[2] + 1) % 26;
      if (mid)  m_pos[1] = (m_pos[1] + 1) % 26;
      if (left) m_pos[0] = (m_pos[0] + 1) % 26;
      x = c;
      for (int i = 2; i >= 0; i--) x = (wt[m_sel[i]][(x + m_pos[i]) % 26] - m_pos[i] + 26) % 26;
      x = rf[x];
      for (int i = 0; i < 3; i++) x = (wi[m_sel[i]][(x + m_pos[i]) % 26] - m_pos[i] + 26) % 26;
      res = x;
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endtask

   task automatic do_load(input string nm, input logic [8:0] sel, input logic [14:0] init);
      @(negedge clk_in);
      rotor_valid_in = 1'b1; rotor_select_in = sel; rotor_initial_in = init;
      @(posedge clk_in); #1;
      rotor_valid_in = 1'b0;
      model_load(sel, init);
      chk({nm, " load pos"}, int'(rotor_pos_out), model_pos());
   endtask

   // Encrypt one letter; optionally pulse both request inputs while busy.
   task automatic do_press(input string nm, input int c, input int inject, output int got);
      int exp, lat;
      bit ready_bad;
      model_press(c, exp);
      @(negedge clk_in);
      letter_valid_in = 1'b1; char_in = 5'(c);
      @(posedge clk_in); #1;
      letter_valid_in = 1'b0;
      lat = -1; got = -1; ready_bad = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk_in); #1;
         if (n == inject) begin
            letter_valid_in = 1'b1; rotor_valid_in = 1'b1; char_in = 5'd7;
            rotor_select_in = 9'h1FF; rotor_initial_in = 15'h1234;
         end else begin
            letter_valid_in = 1'b0; rotor_valid_in = 1'b0;
         end
         if (char_valid_out) begin
            got = int'(char_out); lat = n;
            break;
         end
         if (ready_out) ready_bad = 1'b1;
      end
      chk({nm, " latency"}, lat, LAT_EDGES);
      chk({nm, " char"}, got, exp);
      chk({nm, " ready low while busy"}, int'(ready_bad), 0);
      chk({nm, " pos"}, int'(rotor_pos_out), model_pos());
      @(posedge clk_in); #1;
      chk({nm, " valid one cycle"}, int'(char_valid_out), 0);
      chk({nm, " ready back"}, int'(ready_out), 1);
      chk({nm, " char held"}, int'(char_out), exp);
   endtask

   task automatic watch_idle(input string nm, input int cycles);
      int seen = 0, notready = 0;
      repeat (cycles) begin
         @(posedge clk_in); #1;
         if (char_valid_out) seen++;
         if (!ready_out) notready++;
      end
      chk({nm, " no valid"}, seen, 0);
      chk({nm, " ready stays"}, notready, 0);
   endtask

   typedef struct {
      bit          load;
      logic [8:0]  sel;
      logic [14:0] init;
      logic [4:0]  ch;
      bit          chk_ch;
      logic [4:0]  exp_ch;
      logic [14:0] exp_pos;
   } vec_t;

   vec_t vecs [15];

   initial begin
      int got, tmp;
      vecs[0]  = '{1'b1, 9'h00A, 15'd0, 5'd0, 1'b1, 5'd1, {5'd0, 5'd0, 5'd1}};
      vecs[1]  = '{1'b0, 9'h000, 15'd0, 5'd0, 1'b1, 5'd3, {5'd0, 5'd0, 5'd2}};
      vecs[2]  = '{1'b0, 9'h000, 15'd0, 5'd0, 1'b1, 5'd25, {5'd0, 5'd0, 5'd3}};
      vecs[3]  = '{1'b0, 9'h000, 15'd0, 5'd0, 1'b1, 5'd6, {5'd0, 5'd0, 5'd4}};
      vecs[4]  = '{1'b0, 9'h000, 15'd0, 5'd0, 1'b1, 5'd14, {5'd0, 5'd0, 5'd5}};
      vecs[5]  = '{1'b1, 9'h00A, 15'd0, 5'd1, 1'b1, 5'd0, {5'd0, 5'd0, 5'd1}};
      vecs[6]  = '{1'b0, 9'h000, 15'd0, 5'd3, 1'b1, 5'd0, {5'd0, 5'd0, 5'd2}};
      vecs[7]  = '{1'b0, 9'h000, 15'd0, 5'd25, 1'b1, 5'd0, {5'd0, 5'd0, 5'd3}};
      vecs[8]  = '{1'b0, 9'h000, 15'd0, 5'd6, 1'b1, 5'd0, {5'd0, 5'd0, 5'd4}};
      vecs[9]  = '{1'b0, 9'h000, 15'd0, 5'd14, 1'b1, 5'd0, {5'd0, 5'd0, 5'd5}};
      vecs[10] = '{1'b1, 9'h00A, {5'd0, 5'd3, 5'd20}, 5'd0, 1'b0, 5'd0, {5'd0, 5'd3, 5'd21}};
      vecs[11] = '{1'b0, 9'h000, 15'd0, 5'd0, 1'b0, 5'd0, {5'd0, 5'd4, 5'd22}};
      vecs[12] = '{1'b0, 9'h000, 15'd0, 5'd0, 1'b0, 5'd0, {5'd1, 5'd5, 5'd23}};
      vecs[13] = '{1'b1, 9'h00D, {5'd0, 5'd0, 5'd25}, 5'd0, 1'b0, 5'd0, {5'd0, 5'd1, 5'd0}};
      vecs[14] = '{1'b1, 9'h00A, {5'd30, 5'd2, 5'd30}, 5'd0, 1'b0, 5'd0, {5'd0, 5'd2, 5'd1}};

      build_tables();
      model_reset();
      rst_in = 1'b1; rotor_valid_in = 1'b0; letter_valid_in = 1'b0;
      rotor_select_in = 9'd0; rotor_initial_in = 15'd0; char_in = 5'd0;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in); rst_in = 1'b0;
      @(posedge clk_in); #1;
      chk("reset ready", int'(ready_out), 1);
      chk("reset pos", int'(rotor_pos_out), 0);
      chk("reset char", int'(char_out), 0);
      chk("reset valid", int'(char_valid_out), 0);

      // Known-answer vectors, reciprocity, double-step, wrap, clamp.
      for (int i = 0; i < 15; i++) begin
         if (vecs[i].load) do_load($sformatf("vec%0d", i), vecs[i].sel, vecs[i].init);
         do_press($sformatf("vec%0d", i), int'(vecs[i].ch), 0, got);
         if (vecs[i].chk_ch) chk($sformatf("vec%0d table char", i), got, int'(vecs[i].exp_ch));
         chk($sformatf("vec%0d table pos", i), int'(rotor_pos_out), int'(vecs[i].exp_pos));
      end

      // Requests pulsed during F_M are ignored; no extra result follows.
      do_load("busy", 9'h00A, 15'd0);
      do_press("busy", 0, 2, got);
      watch_idle("busy after", 12);
      chk("busy config kept", int'(rotor_pos_out), model_pos());

      // Illegal letter code in IDLE.
      @(negedge clk_in); letter_valid_in = 1'b1; char_in = 5'd27;
      @(posedge clk_in); #1; letter_valid_in = 1'b0;
      watch_idle("char27", 12);
      chk("char27 pos", int'(rotor_pos_out), model_pos());

      // Config and letter together: config loads, letter dropped.
      @(negedge clk_in);
      rotor_valid_in = 1'b1; letter_valid_in = 1'b1; char_in = 5'd4;
      rotor_select_in = 9'h053; rotor_initial_in = {5'd1, 5'd2, 5'd3};
      @(posedge clk_in); #1;
      rotor_valid_in = 1'b0; letter_valid_in = 1'b0;
      model_load(9'h053, {5'd1, 5'd2, 5'd3});
      watch_idle("both", 12);
      chk("both pos", int'(rotor_pos_out), model_pos());
      do_press("both follow", 4, 0, got);

      // Reset during B_L aborts and restores the reset configuration.
      do_load("rstmid", 9'h0E5, {5'd7, 5'd8, 5'd9});
      @(negedge clk_in); letter_valid_in = 1'b1; char_in = 5'd10;
      @(posedge clk_in); #1; letter_valid_in = 1'b0;
      tmp = 0;
      for (int n = 1; n <= 5; n++) begin
         @(posedge clk_in); #1;
         if (char_valid_out) tmp++;
      end
      rst_in = 1'b1;
      @(posedge clk_in); #1;
      if (char_valid_out) tmp++;
      @(negedge clk_in); rst_in = 1'b0;
      @(posedge clk_in); #1;
      chk("rstmid ready", int'(ready_out), 1);
      chk("rstmid pos", int'(rotor_pos_out), 0);
      chk("rstmid early valid", tmp, 0);
      watch_idle("rstmid", 12);
      model_reset();
      do_press("rstmid after", 0, 0, got);
      chk("rstmid after table char", got, 1);

      // Random configurations and letters against the model.
      for (int it = 0; it < 25; it++) begin
         do_load("rand", 9'($urandom_range(0, 511)), 15'($urandom_range(0, 32767)));
         for (int p = 0, np = $urandom_range(1, 5); p < np; p++)
            do_press("rand", $urandom_range(0, 25), 0, got);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
